// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the branch predictor slice:
//   ctr_t        - 2-bit saturating direction counter states
//   XLEN_DEFAULT - default PC / target address width
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,   // strongly not-taken
        WNT = 2'b01,   // weakly not-taken
        WT  = 2'b10,   // weakly taken
        ST  = 2'b11    // strongly taken
    } ctr_t;

    localparam int unsigned XLEN_DEFAULT = 64;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// ---------------------------------------------------------------------------
// bp_sat_counter
// Next-state logic for one 2-bit saturating direction counter.
// Ports:
//   i_state - current counter state
//   i_taken - resolved branch outcome
//   o_next  - counter state after the update (saturates at SNT / ST)
// ---------------------------------------------------------------------------
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  ctr_t i_state,
    input  logic i_taken,
    output ctr_t o_next
);

    always_comb begin
        o_next = i_state;
        unique case (i_state)
            SNT: o_next = i_taken ? WNT : SNT;
            WNT: o_next = i_taken ? WT  : SNT;
            WT:  o_next = i_taken ? ST  : WNT;
            ST:  o_next = i_taken ? ST  : WT;
            default: o_next = i_state;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped bimodal branch predictor with optional branch target buffer.
// Build option: define BP_BTB_EN to store targets and drive pred_target;
// without it pred_target is tied to zero and only direction is predicted.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   lk_pc           - fetch PC looked up combinationally
//   pred_taken      - predicted-taken flag (hit & counter MSB)
//   pred_target     - predicted target (0 when not predicted taken)
//   upd_valid       - resolved branch present this cycle
//   upd_pc          - PC of the resolved branch
//   upd_taken       - actual outcome
//   upd_target      - actual target
//   upd_mispredict  - EX stage saw a wrong prediction (qualified by upd_valid)
//   flush_tbl       - invalidate all entries
//   mispred_cnt     - wrapping count of mispredictions
// ---------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned TAG_BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lk_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    input  logic            flush_tbl,
    output logic [31:0]     mispred_cnt
);

    localparam int unsigned IDXW = $clog2(ENTRIES);
    localparam int unsigned TLSB = IDXW + 2;
    localparam int unsigned TMSB = IDXW + TAG_BITS + 1;

    logic [ENTRIES-1:0]  r_valid;
    ctr_t                r_ctr [ENTRIES];
    logic [TAG_BITS-1:0] r_tag [ENTRIES];
`ifdef BP_BTB_EN
    logic [XLEN-1:0]     r_target [ENTRIES];
`endif
    logic [31:0]         r_mispred_cnt;

    logic [IDXW-1:0]     w_lk_idx;
    logic [TAG_BITS-1:0] w_lk_tag;
    logic                w_lk_hit;
    logic [IDXW-1:0]     w_upd_idx;
    logic [TAG_BITS-1:0] w_upd_tag;
    logic                w_upd_hit;
    ctr_t                w_ctr_next;
    logic                w_unused_bits;

    assign w_lk_idx  = lk_pc[IDXW+1:2];
    assign w_lk_tag  = lk_pc[TMSB:TLSB];
    assign w_upd_idx = upd_pc[IDXW+1:2];
    assign w_upd_tag = upd_pc[TMSB:TLSB];

    // PC bits outside index/tag (and upd_target without a BTB) are ignored.
    assign w_unused_bits = ^{lk_pc[XLEN-1:TMSB+1], lk_pc[1:0],
                             upd_pc[XLEN-1:TMSB+1], upd_pc[1:0]
`ifndef BP_BTB_EN
                             , upd_target
`endif
                            };

    // Lookup reads registered state only: an update in the same cycle is
    // not visible until after the next edge.
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken = w_lk_hit && r_ctr[w_lk_idx][1];

`ifdef BP_BTB_EN
    assign pred_target = pred_taken ? r_target[w_lk_idx] : '0;
`else
    assign pred_target = '0;
`endif

    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    bp_sat_counter u_sat_counter (
        .i_state (r_ctr[w_upd_idx]),
        .i_taken (upd_taken),
        .o_next  (w_ctr_next)
    );

    // Priority: reset > flush > update. Flush only clears valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= WNT;
                r_tag[i] <= '0;
`ifdef BP_BTB_EN
                r_target[i] <= '0;
`endif
            end
        end else if (flush_tbl) begin
            r_valid <= '0;
        end else if (upd_valid) begin
            if (w_upd_hit) begin
                r_ctr[w_upd_idx] <= w_ctr_next;
`ifdef BP_BTB_EN
                if (upd_taken) begin
                    r_target[w_upd_idx] <= upd_target;
                end
`endif
            end else begin
                // Miss (empty or aliased entry): replace with a weak counter.
                r_valid[w_upd_idx] <= 1'b1;
                r_tag[w_upd_idx]   <= w_upd_tag;
                r_ctr[w_upd_idx]   <= upd_taken ? WT : WNT;
`ifdef BP_BTB_EN
                r_target[w_upd_idx] <= upd_target;
`endif
            end
        end
    end

    // Misprediction count ignores flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mispred_cnt <= '0;
        end else if (upd_valid && upd_mispredict) begin
            r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign mispred_cnt = r_mispred_cnt;

endmodule
